// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples SCLK/CS/MOSI on clk, receives into rx_data and shifts a buffered tx byte onto MISO.
// Optional sticky rx_overrun flag when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave #(
    parameter int unsigned             DATA_WIDTH   = 8,
    parameter int unsigned             SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0]   TX_IDLE_BYTE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic                  rx_overrun,
`endif
    output logic                  busy
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
    logic                    sclk_d, cs_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    byte_done_q, byte_done_d;
    logic [DATA_WIDTH-2:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-2:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
    logic                    tx_full_q, tx_full_d;
    logic                    miso_d, miso_oe_d;
    logic [DATA_WIDTH-1:0]   rx_data_d;
    logic                    rx_valid_d;
    logic                    ovr_q, ovr_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
    logic load_c, done_c;
    logic [DATA_WIDTH-1:0] load_byte_c, new_byte_c;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise_c = sclk_s & ~sclk_d;
    assign sclk_fall_c = ~sclk_s & sclk_d;
    assign cs_rise_c   = cs_s & ~cs_d;
    assign cs_fall_c   = ~cs_s & cs_d;

    assign tx_ready = ~tx_full_q;
    assign busy     = (state_q == ACTIVE);
`ifdef SPI_SLAVE_OVERRUN_EN
    assign rx_overrun = ovr_q;
`endif

    // Next-state and datapath decode
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        miso_d      = miso;
        miso_oe_d   = miso_oe;
        rx_data_d   = rx_data;
        rx_valid_d  = rx_valid;
        ovr_d       = ovr_q;
        load_c      = 1'b0;
        done_c      = 1'b0;
        load_byte_c = tx_full_q ? tx_buf_q : TX_IDLE_BYTE;
        new_byte_c  = {rx_shift_q, mosi_s};

        case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
                if (cs_fall_c) begin
                    load_c      = 1'b1;
                    state_d     = ACTIVE;
                    bit_cnt_d   = '0;
                    byte_done_d = 1'b0;
                    miso_oe_d   = 1'b1;
                end
            end
            ACTIVE: begin
                // cs release wins over a coincident sclk edge
                if (cs_rise_c) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    byte_done_d = 1'b0;
                    miso_d      = 1'b0;
                    miso_oe_d   = 1'b0;
                end else if (sclk_rise_c) begin
                    rx_shift_d = new_byte_c[DATA_WIDTH-2:0];
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d   = '0;
                        byte_done_d = 1'b1;
                        done_c      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall_c) begin
                    if (byte_done_q) begin
                        load_c      = 1'b1;
                        byte_done_d = 1'b0;
                    end else begin
                        miso_d     = tx_shift_q[DATA_WIDTH-2];
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-3:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load consumes the old buffer; a same-cycle write refills it afterwards
        if (load_c) begin
            tx_shift_d = load_byte_c[DATA_WIDTH-2:0];
            miso_d     = load_byte_c[DATA_WIDTH-1];
            tx_full_d  = 1'b0;
        end
        if (tx_valid && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_buf_d  = tx_data;
        end

        if (rx_ack) begin
            rx_valid_d = 1'b0;
            ovr_d      = 1'b0;
        end
        if (done_c) begin
            rx_data_d  = new_byte_c;
            rx_valid_d = 1'b1;
            if (rx_valid && !rx_ack) begin
                ovr_d = 1'b1;
            end
        end
    end

    // Synchronisers, edge history and all state
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync   <= '0;
            cs_sync     <= '1;
            mosi_sync   <= '0;
            sclk_d      <= 1'b0;
            cs_d        <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d      <= sclk_s;
            cs_d        <= cs_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            miso        <= miso_d;
            miso_oe     <= miso_oe_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            ovr_q       <= ovr_d;
        end
    end

endmodule
